mem_bus_fabric: RTL and testbench
=================================

MEM_BUS_FABRIC -- requirements
Module: mem_bus_fabric

Interface
REQ-001 SHALL have parameter N_SLAVES, default 10: number of slave ports, 1..32.
REQ-002 SHALL have parameter SLAVE_BASE, default all zero: N_SLAVES*32-bit packed base addresses; slave i occupies bits [32i+31:32i].
REQ-003 SHALL have parameter SLAVE_MASK, default all zero: N_SLAVES*32-bit packed compare masks, same packing as SLAVE_BASE.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles without slave ready, 1..65535.
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on any error response.
REQ-006 SHALL have port clk  input  1  single clock; all state is updated on the rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port mem_valid  input  1  master request valid.
REQ-009 SHALL have port mem_addr  input  32  master byte address.
REQ-010 SHALL have port mem_ready  output  1  response strobe to the master.
REQ-011 SHALL have port mem_rdata  output  32  read data to the master.
REQ-012 SHALL have port s_sel  output  N_SLAVES  one-hot slave select.
REQ-013 SHALL have port s_ready  input  N_SLAVES  per-slave ready.
REQ-014 SHALL have port s_rdata  input  N_SLAVES*32  packed slave read data, same packing as SLAVE_BASE.
REQ-015 SHALL have port fault_clr  input  1  clears fault_cause.
REQ-016 SHALL have port err_irq  output  1  one-cycle pulse on each error response.
REQ-017 SHALL have port fault_addr  output  32  address of the most recent faulting request.
REQ-018 SHALL have port fault_cause  output  2  sticky cause: 0 none, 1 unmapped, 2 timeout.

Function
REQ-019 SHALL decode slave i as hit when (mem_addr & MASK_i) == BASE_i; when several slaves hit, the lowest index SHALL win (this lets a shadow region overlay another).
REQ-020 SHALL implement the states IDLE, ACCESS and ERR.
REQ-021 SHALL, in IDLE with mem_valid=1 and a hit, register the one-hot winner into s_sel and go to ACCESS on that edge; decode latency SHALL be 1 cycle.
REQ-022 SHALL, in IDLE with mem_valid=1 and no hit, go to ERR with s_sel held at 0.
REQ-023 SHALL, in ACCESS, drive mem_ready = s_ready[k] combinationally and mem_rdata = s_rdata[k], where k is the latched slave index.
REQ-024 SHALL ignore s_ready and s_rdata from every unselected slave.
REQ-025 SHALL, when s_ready[k]=1 in ACCESS, clear s_sel and return to IDLE on that edge.
REQ-026 SHALL keep a 16-bit wait counter that is cleared on entry to ACCESS and increments each ACCESS cycle with s_ready[k]=0.
REQ-027 SHALL treat the cycle in which the wait counter equals TIMEOUT-1 with s_ready[k]=0 as a timeout response: mem_ready=1, mem_rdata=ERR_RDATA, err_irq=1, fault_cause<=2, fault_addr<=mem_addr, s_sel<=0, next state IDLE.
REQ-028 SHALL, if s_ready[k] rises in the same cycle as the timeout, treat it as a normal completion: slave data, no error.
REQ-029 SHALL, in ERR, assert mem_ready=1, mem_rdata=ERR_RDATA and err_irq=1 for exactly one cycle, capture fault_cause<=1 and fault_addr<=mem_addr, then return to IDLE; unmapped latency SHALL be 2 cycles.
REQ-030 SHALL drive mem_ready=0 and mem_rdata=0 in IDLE.
REQ-031 SHALL hold the latched s_sel for the whole of ACCESS, even if mem_addr changes.
REQ-032 SHALL, if mem_valid drops during ACCESS, abort to IDLE with s_sel=0 and no response or error.
REQ-033 SHALL, on fault_clr, set fault_cause to 0 and leave fault_addr unchanged.
REQ-034 SHALL give a new fault priority over a simultaneous fault_clr.
REQ-035 SHALL pass write data and strobes to slaves outside this block; the fabric SHALL be transparent to writes, which handshake identically to reads.

Reset
REQ-036 SHALL, with reset=1 at a clock edge, enter IDLE from any state, including mid-ACCESS.
REQ-037 SHALL, on that reset edge, set s_sel=0, wait counter=0, err_irq=0, fault_addr=0 and fault_cause=0.
REQ-038 SHALL keep mem_ready=0 for the whole time reset is asserted.

Verification
REQ-039 SHALL verify a mapped read: N=3, slave1 BASE=0x2_0000 MASK=0xFFFF_E000; read 0x2_0004 with s_ready[1] asserted on the 2nd ACCESS cycle carrying 0x1234_5678 -> s_sel=3'b010, mem_ready on cycle 3, mem_rdata=0x1234_5678, err_irq=0.
REQ-040 SHALL verify overlap priority: slave0 covers 0x0-0xFFF and slave1 covers 0x0-0x1FFFF; read 0x800 -> s_sel=01; read 0x1800 -> s_sel=10.
REQ-041 SHALL verify an unmapped request: read 0x9000_0000 -> s_sel stays 0, mem_ready and err_irq pulse 1 cycle, mem_rdata=0xDEAD_BEEF, fault_addr=0x9000_0000, fault_cause=1.
REQ-042 SHALL verify timeout: TIMEOUT=4 with the slave never ready -> mem_ready on the 4th ACCESS cycle, fault_cause=2, s_sel=0 afterwards; a repeat with ready on that same 4th cycle -> normal data and no err_irq.
REQ-043 SHALL verify a stray ready: s_ready of an unselected slave pulsed during ACCESS -> mem_ready stays 0.
REQ-044 SHALL verify reset mid-ACCESS -> next cycle IDLE, s_sel=0; fault_clr coincident with a new fault -> fault_cause holds the new cause.

Source files
------------

// File: rtl/mem_bus_fabric.sv
// Single-master address decoder and response mux for N memory-mapped slaves.
// 1-cycle registered decode, per-access wait timeout, sticky fault capture.
module mem_bus_fabric #(
  parameter int                     N_SLAVES   = 10,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = '0,
  parameter int                     TIMEOUT    = 255,
  parameter logic [31:0]            ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [N_SLAVES-1:0]      s_sel,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic                     fault_clr,
  output logic                     err_irq,
  output logic [31:0]              fault_addr,
  output logic [1:0]               fault_cause
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  localparam logic [1:0]  CAUSE_UNMAPPED = 2'd1;
  localparam logic [1:0]  CAUSE_TIMEOUT  = 2'd2;
  localparam logic [15:0] WAIT_LAST      = 16'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [N_SLAVES-1:0] hit;
  logic [N_SLAVES-1:0] win;
  logic [N_SLAVES-1:0] sel_nxt;
  logic [15:0]         wait_cnt, wait_nxt;
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic                resp_rdy;
  logic [31:0]         resp_dat;
  logic                err_resp;
  logic [1:0]          err_cause;

  // Descending scan so the lowest-index hit overwrites the rest.
  always_comb begin
    hit = '0;
    win = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      hit[i] = ((mem_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]);
    end
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

  // The latched one-hot select masks out every unselected slave.
  always_comb begin
    sel_ready = |(s_ready & s_sel);
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      sel_rdata = sel_rdata | (s_rdata[i*32 +: 32] & {32{s_sel[i]}});
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = s_sel;
    wait_nxt  = wait_cnt;
    resp_rdy  = 1'b0;
    resp_dat  = '0;
    err_resp  = 1'b0;
    err_cause = 2'd0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (|hit) begin
            sel_nxt   = win;
            wait_nxt  = '0;
            state_nxt = ACCESS;
          end else begin
            sel_nxt   = '0;
            state_nxt = ERR;
          end
        end
      end
      ACCESS: begin
        resp_dat = sel_rdata;
        if (!mem_valid) begin
          sel_nxt   = '0;
          state_nxt = IDLE;
        end else if (sel_ready) begin
          // Ready wins over a coincident timeout.
          resp_rdy  = 1'b1;
          sel_nxt   = '0;
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          resp_rdy  = 1'b1;
          resp_dat  = ERR_RDATA;
          err_resp  = 1'b1;
          err_cause = CAUSE_TIMEOUT;
          sel_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end
      ERR: begin
        resp_rdy  = 1'b1;
        resp_dat  = ERR_RDATA;
        err_resp  = 1'b1;
        err_cause = CAUSE_UNMAPPED;
        state_nxt = IDLE;
      end
      default: begin
        sel_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign mem_ready = resp_rdy & ~reset;
  assign err_irq   = err_resp & ~reset;
  assign mem_rdata = reset ? 32'd0 : resp_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s_sel       <= '0;
      wait_cnt    <= '0;
      fault_addr  <= '0;
      fault_cause <= '0;
    end else begin
      state    <= state_nxt;
      s_sel    <= sel_nxt;
      wait_cnt <= wait_nxt;
      if (fault_clr) begin
        fault_cause <= '0;
      end
      // A new fault overrides a same-cycle clear.
      if (err_resp) begin
        fault_cause <= err_cause;
        fault_addr  <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench: table of single transactions plus hand sequences for abort/reset/fault corners.
module tb_mem_bus_fabric;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Instance A: slave0 0x0-0xFFF, slave1 0x2_0000-0x2_1FFF, slave2 0x1_0000-0x1_FFFF.
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [2:0]  s_sel;
  logic [2:0]  s_ready;
  logic [95:0] s_rdata;
  logic        fault_clr;
  logic        err_irq;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;

  mem_bus_fabric #(
    .N_SLAVES  (3),
    .SLAVE_BASE({32'h0001_0000, 32'h0002_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_E000, 32'hFFFF_F000}),
    .TIMEOUT   (4),
    .ERR_RDATA (32'hDEAD_BEEF)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .s_sel      (s_sel),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .fault_clr  (fault_clr),
    .err_irq    (err_irq),
    .fault_addr (fault_addr),
    .fault_cause(fault_cause)
  );

  // Instance B: overlapping regions, slave0 0x0-0xFFF shadows slave1 0x0-0x1FFFF.
  logic        b_valid;
  logic [31:0] b_addr;
  logic        b_mem_ready;
  logic [31:0] b_mem_rdata;
  logic [1:0]  b_sel;
  logic [1:0]  b_s_ready;
  logic [63:0] b_s_rdata;
  logic        b_fault_clr;
  logic        b_err_irq;
  logic [31:0] b_fault_addr;
  logic [1:0]  b_fault_cause;

  mem_bus_fabric #(
    .N_SLAVES  (2),
    .SLAVE_BASE({32'h0000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFE_0000, 32'hFFFF_F000})
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (b_valid),
    .mem_addr   (b_addr),
    .mem_ready  (b_mem_ready),
    .mem_rdata  (b_mem_rdata),
    .s_sel      (b_sel),
    .s_ready    (b_s_ready),
    .s_rdata    (b_s_rdata),
    .fault_clr  (b_fault_clr),
    .err_irq    (b_err_irq),
    .fault_addr (b_fault_addr),
    .fault_cause(b_fault_cause)
  );

  typedef struct {
    logic [31:0] addr;
    int          ready_at;   // ACCESS cycle on which ready_vec is pulsed, 0 = never
    logic [2:0]  ready_vec;
    logic [31:0] data;       // placed on the slices named by ready_vec
    logic [2:0]  exp_sel;
    int          exp_cyc;    // cycle of mem_ready, request cycle = 1
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_cause;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_faddr = 32'd0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int          got_cyc;
    logic [31:0] got_dat;
    logic        got_err;
    logic [2:0]  got_sel;
    got_cyc = 0;
    got_dat = '0;
    got_err = 1'b0;
    got_sel = '0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = v.addr;
    s_rdata   = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
    for (int i = 0; i < 3; i++) begin
      if (v.ready_vec[i]) s_rdata[i*32 +: 32] = v.data;
    end
    for (int cyc = 1; cyc <= 12 && got_cyc == 0; cyc++) begin
      s_ready = (v.ready_at != 0 && cyc == v.ready_at + 1) ? v.ready_vec : 3'b000;
      #1;
      if (cyc == 2) got_sel = s_sel;
      if (mem_ready) begin
        got_cyc = cyc;
        got_dat = mem_rdata;
        got_err = err_irq;
      end
      @(negedge clk);
    end
    mem_valid = 1'b0;
    s_ready   = 3'b000;
    #1;
    if (v.exp_err) model_faddr = v.addr;
    chk("txn_sel",       {29'd0, got_sel}, {29'd0, v.exp_sel});
    chk("txn_ready_cyc", got_cyc,          v.exp_cyc);
    chk("txn_rdata",     got_dat,          v.exp_rdata);
    chk("txn_err_irq",   {31'd0, got_err}, {31'd0, v.exp_err});
    chk("txn_sel_after", {29'd0, s_sel},   32'd0);
    chk("txn_cause",     {30'd0, fault_cause}, {30'd0, v.exp_cause});
    chk("txn_faddr",     fault_addr,       model_faddr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               addr           rdy rvec    data           sel    cyc rdata          err cause
    vecs[0] = '{32'h0002_0004, 2, 3'b010, 32'h1234_5678, 3'b010, 3, 32'h1234_5678, 1'b0, 2'd0};
    vecs[1] = '{32'h0000_0ABC, 1, 3'b001, 32'h0BAD_F00D, 3'b001, 2, 32'h0BAD_F00D, 1'b0, 2'd0};
    vecs[2] = '{32'h0001_FFFC, 3, 3'b100, 32'hCAFE_0002, 3'b100, 4, 32'hCAFE_0002, 1'b0, 2'd0};
    vecs[3] = '{32'h0002_1000, 0, 3'b010, 32'h5555_5555, 3'b010, 5, 32'hDEAD_BEEF, 1'b1, 2'd2};
    vecs[4] = '{32'h0002_0008, 4, 3'b010, 32'h4444_0004, 3'b010, 5, 32'h4444_0004, 1'b0, 2'd2};
    vecs[5] = '{32'h9000_0000, 0, 3'b000, 32'h0000_0000, 3'b000, 2, 32'hDEAD_BEEF, 1'b1, 2'd1};
    vecs[6] = '{32'h0002_0010, 2, 3'b100, 32'h6666_6666, 3'b010, 5, 32'hDEAD_BEEF, 1'b1, 2'd2};

    reset       = 1'b1;
    mem_valid   = 1'b1;
    mem_addr    = 32'h9000_0000;
    s_ready     = '0;
    s_rdata     = '0;
    fault_clr   = 1'b0;
    b_valid     = 1'b0;
    b_addr      = '0;
    b_s_ready   = '0;
    b_s_rdata   = {32'hB1B1_B1B1, 32'hB0B0_B0B0};
    b_fault_clr = 1'b0;

    // Reset held with a pending unmapped request: no response may leak out.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_ready", {31'd0, mem_ready},   32'd0);
    chk("rst_err_irq",   {31'd0, err_irq},     32'd0);
    chk("rst_rdata",     mem_rdata,            32'd0);
    chk("rst_sel",       {29'd0, s_sel},       32'd0);
    chk("rst_cause",     {30'd0, fault_cause}, 32'd0);
    chk("rst_faddr",     fault_addr,           32'd0);
    @(negedge clk);
    reset     = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("idle_rdata", mem_rdata, 32'd0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Overlap priority on instance B, each request aborted after decode.
    @(negedge clk);
    b_valid = 1'b1;
    b_addr  = 32'h0000_0800;
    @(negedge clk);
    #1;
    chk("ovl_sel_800", {30'd0, b_sel}, 32'd1);
    b_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("ovl_abort_sel", {30'd0, b_sel}, 32'd0);
    b_valid = 1'b1;
    b_addr  = 32'h0000_1800;
    @(negedge clk);
    #1;
    chk("ovl_sel_1800", {30'd0, b_sel}, 32'd2);
    b_valid = 1'b0;
    @(negedge clk);

    // Address changes mid-ACCESS; slave0 also raises ready but must be ignored.
    mem_valid = 1'b1;
    mem_addr  = 32'h0002_0000;
    s_rdata   = {32'hBAD0_0002, 32'h7777_1111, 32'hBAD0_0000};
    @(negedge clk);
    mem_addr = 32'h0000_0000;
    #1;
    chk("hold_sel", {29'd0, s_sel}, 32'd2);
    @(negedge clk);
    s_ready = 3'b011;
    #1;
    chk("hold_ready", {31'd0, mem_ready}, 32'd1);
    chk("hold_rdata", mem_rdata,          32'h7777_1111);
    @(negedge clk);
    mem_valid = 1'b0;
    s_ready   = 3'b000;

    // mem_valid drops during ACCESS: silent abort.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0002_0000;
    repeat (2) @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chk("abort_ready", {31'd0, mem_ready}, 32'd0);
    chk("abort_irq",   {31'd0, err_irq},   32'd0);
    @(negedge clk);
    #1;
    chk("abort_sel",   {29'd0, s_sel},       32'd0);
    chk("abort_cause", {30'd0, fault_cause}, 32'd2);

    // Reset mid-ACCESS while the selected slave is ready.
    mem_valid = 1'b1;
    mem_addr  = 32'h0002_0000;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    s_ready = 3'b010;
    #1;
    chk("rst_acc_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_acc_sel",   {29'd0, s_sel},       32'd0);
    chk("rst_acc_cause", {30'd0, fault_cause}, 32'd0);
    chk("rst_acc_faddr", fault_addr,           32'd0);
    reset     = 1'b0;
    mem_valid = 1'b0;
    s_ready   = 3'b000;

    // fault_clr coincident with a new unmapped fault, then a plain clear.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h8000_0000;
    @(negedge clk);
    fault_clr = 1'b1;
    #1;
    chk("clr_err_irq", {31'd0, err_irq}, 32'd1);
    @(negedge clk);
    fault_clr = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("clr_new_cause", {30'd0, fault_cause}, 32'd1);
    chk("clr_new_faddr", fault_addr,           32'h8000_0000);
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    #1;
    chk("clr_cause", {30'd0, fault_cause}, 32'd0);
    chk("clr_faddr", fault_addr,           32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
